// File: rtl/imager_fsm_responder_if.sv
// Handshake and pixel-stream bundle between the FPGA memory FSM and the
// imager-side responder.
//   master : FPGA side, drives FSMIND1 / FSMIND0ACK, receives the rest
//   slave  : imager responder, drives FSMIND1ACK / FSMIND0 / im_data*
interface imager_fsm_responder_if;
    logic       FSMIND1;
    logic       FSMIND0ACK;
    logic       FSMIND1ACK;
    logic       FSMIND0;
    logic [5:0] im_data;
    logic       im_data_val;
    logic       im_data_clk;

    modport master (
        output FSMIND1, FSMIND0ACK,
        input  FSMIND1ACK, FSMIND0, im_data, im_data_val, im_data_clk
    );

    modport slave (
        input  FSMIND1, FSMIND0ACK,
        output FSMIND1ACK, FSMIND0, im_data, im_data_val, im_data_clk
    );
endinterface

// File: rtl/imager_fsm_responder.sv
// Imager-side responder for the FSMIND1/FSMIND0 handshake. Acknowledges a
// request after ack_dly+1 cycles, waits rdy_dly+1 cycles, streams
// frame_words 6-bit words (two cycles each, strobe low then high), then
// raises FSMIND0 and waits for the FPGA to acknowledge and release.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ack_dly         request-to-FSMIND1ACK delay minus 1 (latched on request)
//   rdy_dly         FSMIND1ACK-to-first-word delay minus 1 (latched)
//   frame_words     words per frame, 0 = no stream (latched)
//   seed            data pattern start value (latched)
//   bus             handshake / stream interface (slave modport)
//   busy            high whenever the FSM is not idle
//   err_cnt         only with IMG_RESP_ERRCNT_EN: saturating count of
//                   aborts and spurious FSMIND0ACK rising edges
//
// Optional feature macro: IMG_RESP_ERRCNT_EN
//
// state   | meaning
// IDLE    | waiting for FSMIND1, all outputs low
// DLY1    | counting down ack delay
// ACK     | FSMIND1ACK high, counting down ready delay
// STREAM  | emitting words, phase 0 strobe low, phase 1 strobe high
// DONE    | FSMIND0 high, waiting for FSMIND0ACK
// RELEASE | waiting for FSMIND1 and FSMIND0ACK both low
module imager_fsm_responder #(
    parameter int CNT_W   = 24,
    parameter int WORDS_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     ack_dly,
    input  logic [CNT_W-1:0]     rdy_dly,
    input  logic [WORDS_W-1:0]   frame_words,
    input  logic [5:0]           seed,
    imager_fsm_responder_if.slave bus,
    output logic                 busy
`ifdef IMG_RESP_ERRCNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, DLY1, ACK, STREAM, DONE, RELEASE
    } state_t;

    localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);
    localparam logic [WORDS_W-1:0] ONE_W = WORDS_W'(1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     rdy_q;
    logic [WORDS_W-1:0]   words_q;
    logic [WORDS_W-1:0]   idx;
    logic [WORDS_W-1:0]   idx_nxt;
    logic [5:0]           seed_q;
    logic                 phase;
    logic                 abort;

    assign idx_nxt = idx + ONE_W;

    // Losing the request before DONE abandons the frame.
    assign abort = !bus.FSMIND1 &&
                   (state == DLY1 || state == ACK || state == STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rdy_q           <= '0;
            words_q         <= '0;
            idx             <= '0;
            seed_q          <= '0;
            phase           <= 1'b0;
            busy            <= 1'b0;
            bus.FSMIND1ACK  <= 1'b0;
            bus.FSMIND0     <= 1'b0;
            bus.im_data     <= '0;
            bus.im_data_val <= 1'b0;
            bus.im_data_clk <= 1'b0;
        end else if (abort) begin
            state           <= IDLE;
            busy            <= 1'b0;
            bus.FSMIND1ACK  <= 1'b0;
            bus.FSMIND0     <= 1'b0;
            bus.im_data     <= '0;
            bus.im_data_val <= 1'b0;
            bus.im_data_clk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.FSMIND1) begin
                        state   <= DLY1;
                        busy    <= 1'b1;
                        cnt     <= ack_dly;
                        rdy_q   <= rdy_dly;
                        words_q <= frame_words;
                        seed_q  <= seed;
                    end
                end
                DLY1: begin
                    if (cnt == '0) begin
                        state          <= ACK;
                        bus.FSMIND1ACK <= 1'b1;
                        cnt            <= rdy_q;
                    end else begin
                        cnt <= cnt - ONE_C;
                    end
                end
                ACK: begin
                    if (cnt == '0) begin
                        if (words_q == '0) begin
                            state       <= DONE;
                            bus.FSMIND0 <= 1'b1;
                        end else begin
                            state           <= STREAM;
                            idx             <= '0;
                            phase           <= 1'b0;
                            bus.im_data     <= seed_q;
                            bus.im_data_val <= 1'b1;
                            bus.im_data_clk <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - ONE_C;
                    end
                end
                STREAM: begin
                    if (!phase) begin
                        phase           <= 1'b1;
                        bus.im_data_clk <= 1'b1;
                    end else if (idx == words_q - ONE_W) begin
                        // im_data deliberately keeps the last word.
                        state           <= DONE;
                        phase           <= 1'b0;
                        bus.im_data_val <= 1'b0;
                        bus.im_data_clk <= 1'b0;
                        bus.FSMIND0     <= 1'b1;
                    end else begin
                        idx             <= idx_nxt;
                        phase           <= 1'b0;
                        bus.im_data_clk <= 1'b0;
                        bus.im_data     <= seed_q + idx_nxt[5:0];
                    end
                end
                DONE: begin
                    if (bus.FSMIND0ACK) begin
                        state       <= RELEASE;
                        bus.FSMIND0 <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!bus.FSMIND1 && !bus.FSMIND0ACK) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bus.FSMIND1ACK <= 1'b0;
                        bus.im_data    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMG_RESP_ERRCNT_EN
    logic ack0_q;
    logic spurious;

    assign spurious = bus.FSMIND0ACK && !ack0_q && (state != DONE);

    // Coincident abort and spurious ack count once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0_q  <= 1'b0;
            err_cnt <= '0;
        end else begin
            ack0_q <= bus.FSMIND0ACK;
            if ((abort || spurious) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imager_fsm_responder.sv
module tb_imager_fsm_responder;
    localparam int CNT_W   = 24;
    localparam int WORDS_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [CNT_W-1:0]   ack_dly = '0;
    logic [CNT_W-1:0]   rdy_dly = '0;
    logic [WORDS_W-1:0] frame_words = '0;
    logic [5:0]         seed = '0;
    logic               busy;
    logic [7:0]         err_cnt;
    int                 passed = 0;
    int                 total  = 0;
    int                 fails  = 0;
    int                 exp_err = 0;

    imager_fsm_responder_if bus ();

    always #5 clk = ~clk;

    imager_fsm_responder #(.CNT_W(CNT_W), .WORDS_W(WORDS_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ack_dly     (ack_dly),
        .rdy_dly     (rdy_dly),
        .frame_words (frame_words),
        .seed        (seed),
        .bus         (bus),
        .busy        (busy)
`ifdef IMG_RESP_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

`ifndef IMG_RESP_ERRCNT_EN
    assign err_cnt = 8'd0;
`endif

    // Output vector: {FSMIND1ACK, FSMIND0, val, strobe, data[5:0], busy}
    function automatic logic [10:0] outs();
        return {bus.FSMIND1ACK, bus.FSMIND0, bus.im_data_val,
                bus.im_data_clk, bus.im_data, busy};
    endfunction

    // Expected outputs k cycles after the edge that samples the request.
    function automatic logic [10:0] model(int k, int a, int r, int w, int s);
        int st, dn, d;
        logic av, f0, v, dc;
        logic [5:0] dv;
        st = a + r + 2;
        dn = st + 2 * w;
        av = (k >= a + 1);
        f0 = (k >= dn);
        v  = (k >= st) && (k < dn);
        dc = v && (((k - st) % 2) == 1);
        d  = 0;
        if (v) d = (s + (k - st) / 2) % 64;
        else if (k >= dn && w > 0) d = (s + w - 1) % 64;
        dv = d[5:0];
        return {av, f0, v, dc, dv, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [10:0] obs, logic [10:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_err(string tag);
        total++;
        assert (err_cnt === 8'(exp_err)) passed++;
        else begin
            fails++;
            $error("FAIL %s err_cnt observed=%0d expected=%0d", tag, err_cnt, exp_err);
        end
    endtask

    task automatic run_frame(int a, int r, int w, int s, string tag);
        int dn;
        logic [10:0] e;
        dn = a + r + 2 + 2 * w;
        ack_dly     = CNT_W'(a);
        rdy_dly     = CNT_W'(r);
        frame_words = WORDS_W'(w);
        seed        = 6'(s);
        bus.FSMIND1 = 1'b1;
        tick();
        // Latched arguments: later changes must not matter.
        ack_dly     = CNT_W'($urandom_range(0, 50));
        rdy_dly     = CNT_W'($urandom_range(0, 50));
        frame_words = WORDS_W'($urandom_range(0, 50));
        seed        = 6'($urandom);
        for (int k = 0; k <= dn; k++) begin
            check(tag, outs(), model(k, a, r, w, s));
            if (k < dn) tick();
        end
        bus.FSMIND0ACK = 1'b1;
        tick();
        e = model(dn, a, r, w, s);
        e[9] = 1'b0;
        check({tag, "_release"}, outs(), e);
        bus.FSMIND1    = 1'b0;
        bus.FSMIND0ACK = 1'b0;
        tick();
        check({tag, "_idle"}, outs(), 11'd0);
    endtask

    initial begin
        int a, r, w, s;
        bus.FSMIND1    = 1'b0;
        bus.FSMIND0ACK = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset", outs(), 11'd0);
        check_err("reset_err");
        rst = 1'b0;
        tick();

        run_frame(9, 4, 3, 62, "basic");
        run_frame(0, 0, 0, 17, "zero_len");

        for (int i = 0; i < 15; i++) begin
            a = $urandom_range(0, 7);
            r = $urandom_range(0, 7);
            w = $urandom_range(0, 9);
            s = $urandom_range(0, 63);
            run_frame(a, r, w, s, "random");
            repeat ($urandom_range(0, 2)) tick();
        end
        check_err("after_frames_err");

        // Abort during the second stream word.
        ack_dly = 1; rdy_dly = 1; frame_words = 4; seed = 6'd5;
        bus.FSMIND1 = 1'b1;
        tick();
        for (int k = 0; k <= 6; k++) begin
            check("abort_pre", outs(), model(k, 1, 1, 4, 5));
            if (k < 6) tick();
        end
        bus.FSMIND1 = 1'b0;
        tick();
`ifdef IMG_RESP_ERRCNT_EN
        exp_err = 1;
`endif
        check("abort", outs(), 11'd0);
        check_err("abort_err");
        repeat (3) begin
            tick();
            check("abort_hold", outs(), 11'd0);
        end

        // Asynchronous reset while counting the ack delay.
        ack_dly = 9; rdy_dly = 2; frame_words = 2; seed = 6'd40;
        bus.FSMIND1 = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_dly1", outs(), model(2, 9, 2, 2, 40));
        #2 rst = 1'b1;
        #1;
        exp_err = 0;
        check("async_rst", outs(), 11'd0);
        check_err("async_rst_err");
        rst = 1'b0;
        run_frame(9, 2, 2, 40, "after_rst");

        // Spurious FSMIND0ACK pulses in IDLE.
        for (int i = 0; i < 300; i++) begin
            bus.FSMIND0ACK = 1'b1;
            tick();
            check("spurious", outs(), 11'd0);
            bus.FSMIND0ACK = 1'b0;
            tick();
        end
`ifdef IMG_RESP_ERRCNT_EN
        exp_err = 255;
`endif
        check_err("spurious_err");

        run_frame(2, 3, 5, 60, "final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/imager_fsm_responder.md
Name: imager_fsm_responder

Overview:
- Synthesizable imager-side end of the FSMIND0/FSMIND1 handshake. It answers the FPGA memory FSM's FSMIND1 request with FSMIND1ACK and then streams a frame of 6-bit words on im_data/im_data_val/im_data_clk.
- It then signals completion with FSMIND0 and waits for FSMIND0ACK.
- It replaces the behavioural delay model in board-level benches and serves as an on-FPGA loopback source when no sensor is fitted.

Parameters:
- CNT_W, 24, width of the ack/ready delay counters.
- WORDS_W, 16, width of the frame word counter.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it, and the block has no synchronisers.
- rst  in  1  asynchronous, active-high reset.
- ack_dly  in  CNT_W  cycles from request sampled to FSMIND1ACK, minus 1.
- rdy_dly  in  CNT_W  cycles from FSMIND1ACK to first stream word, minus 1.
- frame_words  in  WORDS_W  number of words per frame; 0 means no stream.
- seed  in  6  data pattern seed.
- FSMIND1  in  1  request from the FPGA FSM.
- FSMIND0ACK  in  1  FPGA acknowledge of frame done.
- FSMIND1ACK  out  1  request acknowledge.
- FSMIND0  out  1  frame done.
- im_data  out  6  pixel word.
- im_data_val  out  1  word valid.
- im_data_clk  out  1  word strobe.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered. Asynchronous rst forces state to IDLE and every output to 0, including im_data. Reset mid-transfer abandons the frame and does not emit a partial FSMIND0.
- Arguments ack_dly, rdy_dly, frame_words and seed are latched on the IDLE->DLY1 transition. Changes after that have no effect until the next request.
- States and transitions:
  - IDLE: all outputs 0. FSMIND1=1 at edge N -> DLY1, cnt<=ack_dly.
  - DLY1: at each edge, if cnt==0 -> ACK, FSMIND1ACK<=1, cnt<=rdy_dly; otherwise cnt-1. FSMIND1ACK is therefore first high after edge N+ack_dly+1.
  - ACK: FSMIND1ACK=1. At each edge, if cnt==0 -> STREAM (or DONE if frame_words==0); otherwise cnt-1.
  - STREAM: each word occupies 2 cycles.
    - Phase 0: im_data_val=1, im_data_clk=0, im_data=(seed+idx) mod 64.
    - Phase 1: same data, im_data_clk=1.
    - idx runs 0..frame_words-1 and wraps modulo 64 in the data value only.
    - After phase 1 of the last word -> DONE; im_data_val and im_data_clk go to 0 on the same edge, and im_data holds its last value.
  - DONE: FSMIND0=1, FSMIND1ACK=1. FSMIND0ACK=1 -> RELEASE, FSMIND0<=0.
  - RELEASE: FSMIND1ACK=1. When both FSMIND1=0 and FSMIND0ACK=0 -> IDLE, FSMIND1ACK<=0.
- Abort: FSMIND1=0 sampled in DLY1, ACK or STREAM -> IDLE next edge with all outputs cleared, which matches the legacy bench model. FSMIND1=0 in DONE is not an abort; the block waits for FSMIND0ACK.
- FSMIND0ACK=1 outside DONE is ignored. A request re-asserted in the same cycle as RELEASE->IDLE is taken on the following edge; no back-to-back merge.
- busy = (state != IDLE), registered with the state.
- Counter arithmetic is unsigned. Maximum delays are 2^CNT_W cycles and maximum frame is 2^WORDS_W - 1 words.

Optional Feature:
- Macro IMG_RESP_ERRCNT_EN.
- When defined:
  - The block adds output err_cnt (8 bits, reset 0).
  - err_cnt increments by 1 on each abort and on each cycle FSMIND0ACK rises (0->1) outside DONE.
  - err_cnt saturates at 255.
  - If both events occur in the same cycle it increments by 1 only.
- When undefined: no err_cnt port and no counter logic; the FSM behaviour is identical.

Test Plan:
- Basic frame: rst 4 cycles, ack_dly=9, rdy_dly=4, frame_words=3, seed=62, FSMIND1 high at edge N -> FSMIND1ACK high after N+10; first im_data_val at N+15; data 62,63,0, each held 2 cycles with im_data_clk 0 then 1; FSMIND0 high after N+21.
- Completion handshake: in DONE assert FSMIND0ACK -> FSMIND0 low next edge; drop FSMIND1 and FSMIND0ACK -> FSMIND1ACK low next edge, busy 0.
- Zero-length frame: frame_words=0, ack_dly=0, rdy_dly=0 -> FSMIND1ACK after N+1, FSMIND0 after N+2, im_data_val never high.
- Abort: drop FSMIND1 during the second stream word -> all outputs 0 next edge, FSMIND0 never asserted; with IMG_RESP_ERRCNT_EN, err_cnt=1.
- Async reset mid-DLY1 (rst pulse between edges) -> outputs 0 immediately; a new request afterwards restarts full ack_dly timing.
- Spurious ack: pulse FSMIND0ACK in IDLE 300 times with IMG_RESP_ERRCNT_EN -> no state change, err_cnt saturates at 255.
